// File: rtl/yarvi_trace_fifo_if.sv
// rtl/yarvi_trace_fifo_if.sv - commit-trace producer/consumer signal bundle
interface yarvi_trace_fifo_if #(
   parameter int XLEN       = 32,
   parameter int DEPTH_LOG2 = 3
);
   logic                  in_valid;
   logic [3:0]            in_info;
   logic [1:0]            in_prv;
   logic [XLEN-1:0]       in_pc;
   logic [31:0]           in_insn;
   logic [4:0]            in_wb_rd;
   logic [XLEN-1:0]       in_wb_val;
   logic                  out_valid;
   logic                  out_ready;
   logic [3:0]            out_info;
   logic [1:0]            out_prv;
   logic [XLEN-1:0]       out_pc;
   logic [31:0]           out_insn;
   logic [4:0]            out_wb_rd;
   logic [XLEN-1:0]       out_wb_val;
   logic                  out_lost;
   logic [15:0]           drop_count;
   logic [DEPTH_LOG2:0]   count;

   modport master (
      output in_valid, in_info, in_prv, in_pc, in_insn, in_wb_rd, in_wb_val, out_ready,
      input  out_valid, out_info, out_prv, out_pc, out_insn, out_wb_rd, out_wb_val,
      input  out_lost, drop_count, count
   );

   modport slave (
      input  in_valid, in_info, in_prv, in_pc, in_insn, in_wb_rd, in_wb_val, out_ready,
      output out_valid, out_info, out_prv, out_pc, out_insn, out_wb_rd, out_wb_val,
      output out_lost, drop_count, count
   );
endinterface

// File: rtl/yarvi_trace_fifo.sv
// rtl/yarvi_trace_fifo.sv - commit-trace FIFO with drop counting and lost flag
module yarvi_trace_fifo #(
   parameter int XLEN       = 32,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   yarvi_trace_fifo_if.slave tif
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;

   // Extra pointer MSB tells full from empty when the index bits match.
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [15:0]     drop_q, drop_d;
   logic            lost_q, lost_d;

   logic [3:0]      info_q   [DEPTH];
   logic [1:0]      prv_q    [DEPTH];
   logic [XLEN-1:0] pc_q     [DEPTH];
   logic [31:0]     insn_q   [DEPTH];
   logic [4:0]      rd_q     [DEPTH];
   logic [XLEN-1:0] val_q    [DEPTH];
   logic            lostb_q  [DEPTH];

   logic [PW-1:0]         occ;
   logic                  full;
   logic                  not_empty;
   logic                  push;
   logic                  pop;
   logic                  drop;
   logic [DEPTH_LOG2-1:0] widx;
   logic [DEPTH_LOG2-1:0] ridx;

   assign occ       = wptr_q - rptr_q;
   assign full      = occ[DEPTH_LOG2];
   assign not_empty = (occ != '0);
   assign pop       = not_empty && tif.out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push      = tif.in_valid && (!full || pop);
   assign drop      = tif.in_valid && full && !pop;
   assign widx      = wptr_q[DEPTH_LOG2-1:0];
   assign ridx      = rptr_q[DEPTH_LOG2-1:0];

   // Next-state for pointers, saturating drop counter and pending-loss marker.
   always_comb begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
      drop_d = drop_q;
      lost_d = lost_q;
      if (drop) begin
         lost_d = 1'b1;
         if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end else if (push) begin
         lost_d = 1'b0;
      end
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         drop_q <= '0;
         lost_q <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         drop_q <= drop_d;
         lost_q <= lost_d;
      end
   end

   // Record storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clock) begin
      if (reset_n && push) begin
         info_q[widx]  <= tif.in_info;
         prv_q[widx]   <= tif.in_prv;
         pc_q[widx]    <= tif.in_pc;
         insn_q[widx]  <= tif.in_insn;
         rd_q[widx]    <= tif.in_wb_rd;
         val_q[widx]   <= (tif.in_wb_rd == 5'd0) ? '0 : tif.in_wb_val;
         lostb_q[widx] <= lost_q;
      end
   end

   // Head is read straight from storage and forced to zero when empty.
   assign tif.out_valid  = not_empty;
   assign tif.out_info   = not_empty ? info_q[ridx]  : '0;
   assign tif.out_prv    = not_empty ? prv_q[ridx]   : '0;
   assign tif.out_pc     = not_empty ? pc_q[ridx]    : '0;
   assign tif.out_insn   = not_empty ? insn_q[ridx]  : '0;
   assign tif.out_wb_rd  = not_empty ? rd_q[ridx]    : '0;
   assign tif.out_wb_val = not_empty ? val_q[ridx]   : '0;
   assign tif.out_lost   = not_empty ? lostb_q[ridx] : 1'b0;
   assign tif.drop_count = drop_q;
   assign tif.count      = occ;
endmodule

// File: tb/tb_yarvi_trace_fifo.sv
// tb/tb_yarvi_trace_fifo.sv - directed self-checking bench for yarvi_trace_fifo
module tb_yarvi_trace_fifo;
   logic clock;
   logic reset_n;
   int   total;
   int   bad;

   yarvi_trace_fifo_if #(.XLEN(32), .DEPTH_LOG2(3)) tif ();

   yarvi_trace_fifo #(.XLEN(32), .DEPTH_LOG2(3)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .tif     (tif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_rec(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val);
      tif.in_valid  = 1'b1;
      tif.in_info   = pc[5:2];
      tif.in_prv    = 2'd3;
      tif.in_pc     = pc;
      tif.in_insn   = 32'h0000_0013 | {pc[11:0], 20'd0};
      tif.in_wb_rd  = rd;
      tif.in_wb_val = val;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set_rec(32'hDEAD_BEEC, 5'd7, 32'h5555_AAAA);
      tif.out_ready = 1'b0;
      step();
      step();
      total++; if (tif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", tif.out_valid); end
      total++; if (tif.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", tif.count); end
      total++; if (tif.drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0h exp=0", tif.drop_count); end
      total++; if ({tif.out_pc, tif.out_insn, tif.out_wb_val} !== 96'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", {tif.out_pc, tif.out_insn, tif.out_wb_val}); end
      total++; if ({tif.out_info, tif.out_prv, tif.out_wb_rd, tif.out_lost} !== 12'd0) begin bad++; $display("FAIL reset_fields got=%h exp=0", {tif.out_info, tif.out_prv, tif.out_wb_rd, tif.out_lost}); end
      tif.in_valid = 1'b0;
      reset_n = 1'b1;
      step();
      total++; if (tif.count !== 4'd0) begin bad++; $display("FAIL reset_idle_count got=%0d exp=0", tif.count); end
   endtask

   task automatic test_single();
      tif.out_ready = 1'b1;
      tif.in_valid  = 1'b1;
      tif.in_info   = 4'hA;
      tif.in_prv    = 2'd3;
      tif.in_pc     = 32'h8000_0000;
      tif.in_insn   = 32'h0000_0013;
      tif.in_wb_rd  = 5'd0;
      tif.in_wb_val = 32'h0000_1234;
      step();
      tif.in_valid = 1'b0;
      total++; if (tif.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", tif.out_valid); end
      total++; if (tif.out_pc !== 32'h8000_0000) begin bad++; $display("FAIL single_pc got=%h exp=80000000", tif.out_pc); end
      total++; if (tif.out_wb_val !== 32'd0) begin bad++; $display("FAIL single_wbval got=%h exp=0", tif.out_wb_val); end
      total++; if (tif.out_insn !== 32'h0000_0013) begin bad++; $display("FAIL single_insn got=%h exp=13", tif.out_insn); end
      total++; if ({tif.out_info, tif.out_prv, tif.out_lost} !== 7'b1010_11_0) begin bad++; $display("FAIL single_fields got=%b exp=1010110", {tif.out_info, tif.out_prv, tif.out_lost}); end
      total++; if (tif.count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", tif.count); end
      step();
      total++; if (tif.count !== 4'd0) begin bad++; $display("FAIL single_drain_count got=%0d exp=0", tif.count); end
      total++; if (tif.out_pc !== 32'd0) begin bad++; $display("FAIL single_empty_pc got=%h exp=0", tif.out_pc); end
   endtask

   task automatic test_overflow();
      tif.out_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         set_rec(32'h100 + 32'(4 * k), 5'(k + 1), 32'(k * 17));
         step();
      end
      tif.in_valid = 1'b0;
      total++; if (tif.count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", tif.count); end
      total++; if (tif.drop_count !== 16'd2) begin bad++; $display("FAIL ovf_drop got=%0d exp=2", tif.drop_count); end
      tif.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         total++; if (tif.out_valid !== 1'b1 || tif.out_pc !== 32'h100 + 32'(4 * k)) begin bad++; $display("FAIL ovf_order[%0d] got=%0h/%h exp=1/%h", k, tif.out_valid, tif.out_pc, 32'h100 + 32'(4 * k)); end
         total++; if (tif.out_lost !== 1'b0) begin bad++; $display("FAIL ovf_lost[%0d] got=%0h exp=0", k, tif.out_lost); end
         total++; if (tif.out_wb_val !== 32'(k * 17) || tif.out_wb_rd !== 5'(k + 1)) begin bad++; $display("FAIL ovf_wb[%0d] got=%0d/%h exp=%0d/%h", k, tif.out_wb_rd, tif.out_wb_val, k + 1, k * 17); end
         step();
      end
      total++; if (tif.count !== 4'd0 || tif.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0d/%0h exp=0/0", tif.count, tif.out_valid); end
   endtask

   task automatic test_lost_flag();
      logic [31:0] exp_pc   [10];
      logic        exp_lost [10];
      // Loss left pending by the previous overflow lands on the first record here.
      tif.out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         set_rec(32'h300 + 32'(4 * k), 5'd1, 32'(k));
         step();
      end
      set_rec(32'h200, 5'd1, 32'h200);
      step();
      total++; if (tif.drop_count !== 16'd3) begin bad++; $display("FAIL lost_drop got=%0d exp=3", tif.drop_count); end
      tif.in_valid  = 1'b0;
      tif.out_ready = 1'b1;
      total++; if (tif.out_pc !== 32'h300 || tif.out_lost !== 1'b1) begin bad++; $display("FAIL lost_first got=%h/%0h exp=300/1", tif.out_pc, tif.out_lost); end
      step();
      tif.out_ready = 1'b0;
      set_rec(32'h204, 5'd1, 32'h204);
      step();
      total++; if (tif.count !== 4'd8) begin bad++; $display("FAIL lost_refill got=%0d exp=8", tif.count); end
      // Full with a simultaneous pop: push accepted.
      tif.out_ready = 1'b1;
      set_rec(32'h208, 5'd1, 32'h208);
      step();
      tif.in_valid = 1'b0;
      total++; if (tif.drop_count !== 16'd3 || tif.count !== 4'd8) begin bad++; $display("FAIL lost_pushpop got=%0d/%0d exp=3/8", tif.drop_count, tif.count); end
      exp_pc = '{32'h308, 32'h30C, 32'h310, 32'h314, 32'h318, 32'h31C, 32'h204, 32'h208, 32'h0, 32'h0};
      exp_lost = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 8; k++) begin
         total++; if (tif.out_pc !== exp_pc[k] || tif.out_lost !== exp_lost[k]) begin bad++; $display("FAIL lost_seq[%0d] got=%h/%0h exp=%h/%0h", k, tif.out_pc, tif.out_lost, exp_pc[k], exp_lost[k]); end
         step();
      end
      total++; if (tif.out_valid !== 1'b0) begin bad++; $display("FAIL lost_empty got=%0h exp=0", tif.out_valid); end
   endtask

   task automatic test_back_to_back();
      tif.out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         set_rec(32'h400 + 32'(4 * k), 5'd2, 32'(k));
         step();
      end
      total++; if (tif.count !== 4'd8) begin bad++; $display("FAIL b2b_fill got=%0d exp=8", tif.count); end
      tif.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         set_rec(32'h420 + 32'(4 * i), 5'd2, 32'(i + 8));
         total++; if (tif.out_pc !== 32'h400 + 32'(4 * i) || tif.out_lost !== 1'b0) begin bad++; $display("FAIL b2b_head[%0d] got=%h/%0h exp=%h/0", i, tif.out_pc, tif.out_lost, 32'h400 + 32'(4 * i)); end
         step();
         total++; if (tif.count !== 4'd8) begin bad++; $display("FAIL b2b_count[%0d] got=%0d exp=8", i, tif.count); end
      end
      tif.in_valid = 1'b0;
      total++; if (tif.drop_count !== 16'd3) begin bad++; $display("FAIL b2b_drop got=%0d exp=3", tif.drop_count); end
      for (int i = 20; i < 28; i++) begin
         total++; if (tif.out_pc !== 32'h400 + 32'(4 * i) || tif.out_wb_val !== 32'(i)) begin bad++; $display("FAIL b2b_tail[%0d] got=%h/%h exp=%h/%h", i, tif.out_pc, tif.out_wb_val, 32'h400 + 32'(4 * i), i); end
         step();
      end
      total++; if (tif.count !== 4'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", tif.count); end
   endtask

   task automatic test_saturate_and_reset();
      tif.out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         set_rec(32'h500 + 32'(4 * k), 5'd3, 32'(k));
         step();
      end
      // Already 3 drops; 65531 more reach 16'hFFFE.
      set_rec(32'h600, 5'd3, 32'h600);
      for (int k = 0; k < 65531; k++) step();
      total++; if (tif.drop_count !== 16'hFFFE) begin bad++; $display("FAIL sat_fffe got=%h exp=fffe", tif.drop_count); end
      for (int k = 0; k < 3; k++) step();
      total++; if (tif.drop_count !== 16'hFFFF) begin bad++; $display("FAIL sat_ffff got=%h exp=ffff", tif.drop_count); end
      tif.in_valid  = 1'b0;
      tif.out_ready = 1'b1;
      step();
      step();
      step();
      total++; if (tif.count !== 4'd5 || tif.out_pc !== 32'h50C) begin bad++; $display("FAIL sat_drain got=%0d/%h exp=5/50c", tif.count, tif.out_pc); end
      reset_n = 1'b0;
      step();
      total++; if (tif.count !== 4'd0 || tif.out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_occ got=%0d/%0h exp=0/0", tif.count, tif.out_valid); end
      total++; if (tif.drop_count !== 16'd0 || tif.out_pc !== 32'd0) begin bad++; $display("FAIL mid_reset_state got=%h/%h exp=0/0", tif.drop_count, tif.out_pc); end
      reset_n = 1'b1;
      tif.out_ready = 1'b0;
      set_rec(32'h700, 5'd4, 32'h77);
      step();
      tif.in_valid = 1'b0;
      total++; if (tif.out_pc !== 32'h700 || tif.out_lost !== 1'b0 || tif.out_wb_val !== 32'h77) begin bad++; $display("FAIL post_reset got=%h/%0h/%h exp=700/0/77", tif.out_pc, tif.out_lost, tif.out_wb_val); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset_n       = 1'b0;
      tif.in_valid  = 1'b0;
      tif.in_info   = '0;
      tif.in_prv    = '0;
      tif.in_pc     = '0;
      tif.in_insn   = '0;
      tif.in_wb_rd  = '0;
      tif.in_wb_val = '0;
      tif.out_ready = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_lost_flag();
      test_back_to_back();
      test_saturate_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
